// File: rtl/drum_pkg.sv
// Shared types and helpers for the DRUM-style sequential approximate multiplier.
package drum_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StMul,
    StDenorm,
    StOut
  } state_e;

  // Width of a shift counter that must reach n-k; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned k);
    int unsigned w;
    w = $clog2(n - k + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/drum_norm.sv
// One operand normaliser: left-shifts until the MSB is set or the cap is hit,
// then presents the top K bits as the window (optionally LSB-rounded).
module drum_norm
  import drum_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned K  = 8,
  parameter int unsigned CW = cnt_width(N, K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [N-1:0]  x,
  input  logic          round_en,
  output logic          done,
  output logic [K-1:0]  window,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] Cap = CW'(N - K);

  logic [N-1:0]  x_q;
  logic [CW-1:0] cnt_q;

  assign done  = x_q[N-1] | (cnt_q == Cap);
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      x_q   <= x;
      cnt_q <= '0;
    end else if (shift && !done) begin
      x_q   <= x_q << 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Rounding only applies when low-order bits were actually dropped.
  always_comb begin
    window = x_q[N-1 -: K];
    if (round_en && (cnt_q < Cap)) window[0] = 1'b1;
  end

endmodule

// File: rtl/drum_mult_seq.sv
// Sequential DRUM approximate multiplier: parallel normalisation, K-cycle
// shift-add of the two windows, then a single barrel shift back to scale.
module drum_mult_seq
  import drum_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned K = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           round_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int unsigned CW = cnt_width(N, K);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned MW = $clog2(K);
  localparam int unsigned PW = 2 * N;
  localparam logic [CW-1:0] Cap = CW'(N - K);

  state_e state_q, state_d;

  logic            rnd_q;
  logic [2*K-1:0]  wa_q;
  logic [K-1:0]    wb_q;
  logic [2*K-1:0]  acc_q;
  logic [MW-1:0]   mc_q;
  logic [PW-1:0]   p_q;

  logic            done_a, done_b;
  logic [K-1:0]    win_a, win_b;
  logic [CW-1:0]   sa, sb;
  logic [SW-1:0]   shamt;
  logic            accept;

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign p         = p_q;
  assign accept    = in_valid & in_ready;
  assign shamt     = SW'(Cap - sa) + SW'(Cap - sb);

  drum_norm #(.N(N), .K(K), .CW(CW)) u_norm_a (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state_q == StNorm),
    .x        (a),
    .round_en (rnd_q),
    .done     (done_a),
    .window   (win_a),
    .count    (sa)
  );

  drum_norm #(.N(N), .K(K), .CW(CW)) u_norm_b (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (state_q == StNorm),
    .x        (b),
    .round_en (rnd_q),
    .done     (done_b),
    .window   (win_b),
    .count    (sb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StNorm;
      StNorm:   if (done_a && done_b) state_d = StMul;
      StMul:    if (mc_q == MW'(K - 1)) state_d = StDenorm;
      StDenorm: state_d = StOut;
      StOut:    if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q <= 1'b0;
      wa_q  <= '0;
      wb_q  <= '0;
      acc_q <= '0;
      mc_q  <= '0;
      p_q   <= '0;
    end else begin
      case (state_q)
        StIdle: if (in_valid) rnd_q <= round_en;
        StNorm: begin
          if (done_a && done_b) begin
            wa_q  <= (2*K)'(win_a);
            wb_q  <= win_b;
            acc_q <= '0;
            mc_q  <= '0;
          end
        end
        // LSB-first on wb; the multiplicand walks left into the 2K-bit accumulator.
        StMul: begin
          if (wb_q[0]) acc_q <= acc_q + wa_q;
          wa_q <= wa_q << 1;
          wb_q <= wb_q >> 1;
          mc_q <= mc_q + 1'b1;
        end
        StDenorm: p_q <= PW'(acc_q) << shamt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_mult_seq.sv
// Self-checking bench for drum_mult_seq: directed plan vectors, randomized jobs
// against an arithmetic model, backpressure, busy-time input and mid-job reset.
module tb_drum_mult_seq;

  localparam int N = 16;
  localparam int K = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          round_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*N-1:0] p;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drum_mult_seq #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .round_en  (round_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // Leading-zero count of x, capped at N-K.
  function automatic int norm_shift(input logic [N-1:0] x);
    int s = 0;
    while (s < N - K && x[N-1-s] == 1'b0) s++;
    return s;
  endfunction

  function automatic logic [2*N-1:0] model_p(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic r);
    int sx, sy;
    longint unsigned wx, wy, prod;
    sx = norm_shift(x);
    sy = norm_shift(y);
    wx = (longint'(x) * (longint'(1) << sx)) / (longint'(1) << (N - K));
    wy = (longint'(y) * (longint'(1) << sy)) / (longint'(1) << (N - K));
    wx = wx % (longint'(1) << K);
    wy = wy % (longint'(1) << K);
    if (r && sx < N - K) wx = wx | 1;
    if (r && sy < N - K) wy = wy | 1;
    prod = (wx * wy) * (longint'(1) << ((N - K - sx) + (N - K - sy)));
    return prod[2*N-1:0];
  endfunction

  function automatic int model_lat(input logic [N-1:0] x, input logic [N-1:0] y);
    int sx, sy;
    sx = norm_shift(x);
    sy = norm_shift(y);
    return ((sx > sy) ? sx : sy) + K + 3;
  endfunction

  // Runs one job; lat counts clock edges from the accept edge (counted as 1)
  // through the first edge after which out_valid is high.
  task automatic do_job(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tr,
                        input int hold, output logic [2*N-1:0] obs, output int lat,
                        output bit timeout);
    @(negedge clk);
    a = ta; b = tb; round_en = tr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    timeout = !out_valid;
    obs = p;
    repeat (hold) @(posedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (p !== '0) begin errors++; $display("FAIL reset_p got %h want 0", p); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0]   va [4] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h1234};
    logic [N-1:0]   vb [4] = '{16'h00FF, 16'hFFFF, 16'h0100, 16'h0100};
    logic           vr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2*N-1:0] vp [4] = '{32'h0000FE01, 32'hFE010000, 32'h00122000, 32'h00124440};
    int             vl [4] = '{19, 11, 18, 18};
    logic [2*N-1:0] obs;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_job(va[i], vb[i], vr[i], 0, obs, lat, to);
      checks++;
      if (to) begin errors++; $display("FAIL directed%0d_timeout out_valid never rose", i); end
      checks++;
      if (obs !== vp[i]) begin errors++; $display("FAIL directed%0d_p got %h want %h", i, obs, vp[i]); end
      checks++;
      if (lat != vl[i]) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_zero_busy();
    int lat = 1;
    int ready_hi = 0;
    logic [2*N-1:0] expv;
    expv = model_p(16'h0000, 16'hBEEF, 1'b0);
    @(negedge clk);
    a = 16'h0000; b = 16'hBEEF; round_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_hi++;
      if (lat == 3) begin a = 16'hFFFF; b = 16'hFFFF; round_en = 1'b1; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checks++; if (!out_valid) begin errors++; $display("FAIL zero_timeout out_valid never rose"); end
    checks++; if (ready_hi != 0) begin errors++; $display("FAIL zero_in_ready_busy got %0d high cycles want 0", ready_hi); end
    checks++; if (p !== expv) begin errors++; $display("FAIL zero_p got %h want %h", p, expv); end
    checks++; if (lat != model_lat(16'h0000, 16'hBEEF)) begin
      errors++; $display("FAIL zero_latency got %0d want %0d", lat, model_lat(16'h0000, 16'hBEEF));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_no_second_job busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [2*N-1:0] expv, first;
    int lat = 1;
    int unstable = 0;
    expv = model_p(16'h0ABC, 16'h7001, 1'b1);
    @(negedge clk);
    a = 16'h0ABC; b = 16'h7001; round_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    first = p;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || p !== first || in_ready) unstable++;
    end
    checks++; if (first !== expv) begin errors++; $display("FAIL bp_p got %h want %h", first, expv); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after got %b want 0", out_valid); end
    checks++; if (p !== expv) begin errors++; $display("FAIL bp_p_kept got %h want %h", p, expv); end
  endtask

  task automatic test_reset_mid();
    logic [2*N-1:0] obs;
    int lat;
    bit to;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; round_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (p !== '0) begin errors++; $display("FAIL rstmid_p got %h want 0", p); end
    do_job(16'h3C5A, 16'h0093, 1'b1, 1, obs, lat, to);
    checks++;
    if (to || obs !== model_p(16'h3C5A, 16'h0093, 1'b1)) begin
      errors++; $display("FAIL rstmid_next_job got %h want %h", obs, model_p(16'h3C5A, 16'h0093, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    logic rr;
    logic [2*N-1:0] obs, expv;
    int lat, expl;
    bit to;
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom >> $urandom_range(0, 31));
      rb = N'($urandom >> $urandom_range(0, 31));
      rr = 1'($urandom_range(0, 1));
      expv = model_p(ra, rb, rr);
      expl = model_lat(ra, rb);
      do_job(ra, rb, rr, $urandom_range(0, 2), obs, lat, to);
      checks++;
      if (to || obs !== expv) begin
        errors++; $display("FAIL rand%0d_p a=%h b=%h r=%b got %h want %h", i, ra, rb, rr, obs, expv);
      end
      checks++;
      if (lat != expl) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, expl); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_busy();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_mult_seq.md
Name: drum_mult_seq

Overview:
- Parametrised sequential dynamic-range (DRUM-style) approximate multiplier for unsigned N-bit operands.
- Each operand is normalised by left-shifting until its MSB is set, capped at N-K shifts. The top K bits of each form a window.
- The two windows are multiplied by a K-cycle shift-add. The product is then scaled back by one barrel shift.
- Successor to the fixed 16/8 controller-plus-datapath multiplier. Adds width/window parameters, a valid/ready handshake on both sides, parallel normalisation of both operands and optional LSB rounding.

Parameters:
- N, 16, operand width; N >= 4.
- K, 8, window width; 2 <= K <= N.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  N  operand A, unsigned.
- b  in  N  operand B, unsigned.
- round_en  in  1  force window LSB to 1 when bits were truncated; sampled with the operands.
- out_valid  out  1  result available; high only in OUT.
- out_ready  in  1  consumer accepts result.
- p  out  2N  approximate product; held stable while out_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, p=0, all internal registers 0.
- rst has priority over every other event; reset mid-operation discards the job with no output.
- States: IDLE, NORM, MUL, DENORM, OUT.
- IDLE
  - On in_valid & in_ready: latch a, b and round_en; clear shift counters sa and sb; go to NORM.
- NORM (per operand x in {a,b}, in parallel)
  - Operand x is done when x[N-1]=1 or its shift count = N-K.
  - Each cycle, every not-done operand shifts left by 1 and its count increments.
  - When both are done in the same evaluation, go to MUL.
  - NORM occupies max(sa,sb)+1 cycles.
  - Zero operand: counts to N-K, window 0.
- Window: w = x_shifted[N-1:N-K]. If round_en=1 and shift count < N-K, then w[0] is forced to 1.
  - When K=N: no truncation, rounding never applies, and the result is exact.
- MUL
  - Shift-add over exactly K cycles, LSB-first on wb.
  - 2K-bit accumulator; no overflow is possible.
  - The product is not computed in a single cycle.
- DENORM
  - One cycle: p <= product << ((N-K-sa)+(N-K-sb)).
  - The shift is at most 2(N-K), so the result fits in 2N bits.
- OUT
  - out_valid=1 and p is held until out_ready.
  - On out_valid & out_ready: go to IDLE. in_ready rises the next cycle, giving no back-to-back accept.
  - in_valid is ignored outside IDLE.
- Latency from the accept edge to the first cycle with out_valid: max(sa,sb)+K+3 clock edges. Fixed by data, independent of out_ready.
- p keeps its last value after the handshake until the next DENORM.

Decomposition:
- Package drum_pkg holds:
  - the state enum (IDLE, NORM, MUL, DENORM, OUT);
  - a clog2-based width function for the shift counters: width clog2(N-K+1), minimum 1.
- One sub-module, drum_norm, instanced twice (A and B):
  - shift register and capped counter;
  - outputs: done, window (with rounding) and count.
- Top level holds the FSM, the shift-add multiplier and the output barrel shift.

Test Plan:
- N=16, K=8, a=0x00FF, b=0x00FF, round_en=0 -> sa=sb=8, p=0x0000FE01 (exact); out_valid 19 edges after accept.
- a=0xFFFF, b=0xFFFF, round_en=1 -> sa=sb=0, windows 0xFF, p=0xFE010000; out_valid 11 edges after accept.
- a=0x1234, b=0x0100:
  - round_en=0 -> windows 0x91 and 0x80, scale 6, p=0x00122000.
  - round_en=1 -> windows 0x91 and 0x81, p=0x00124440.
- a=0x0000, b=0xBEEF -> p=0; in_ready stays low for the whole job; a second in_valid pulse during busy is ignored.
- Hold out_ready=0 for 5 cycles in OUT -> p and out_valid stable. Then handshake -> IDLE, and in_ready=1 one cycle later.
- Assert rst during MUL -> next cycle in_ready=1, busy=0, out_valid=0, p=0. A subsequent job completes correctly.
